// File: rtl/seq_det_ctrl.sv
// Configurable serial-pattern detection controller: a config handshake loads
// pattern/length/window, and each start runs one window of overlapping matching on seq_in.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int WIN_W   = 16,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               abort,
  input  logic               seq_in,
  output logic               seq_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   det_cnt,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [WIN_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               err_q, err_d;

  logic               cfg_take;
  logic               cfg_legal;
  logic [MAX_LEN-1:0] sample_vec;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_nx;
  logic               fill_ok;
  logic               hit;

  assign cfg_ready = (state_q != RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign det_cnt   = cnt_q;
  assign seq_out   = hit_q;
  assign err       = err_q;

  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN)) && (cfg_window != '0);

  // The sample being taken this cycle is appended as the newest bit before comparing.
  assign sample_vec = {hist_q[MAX_LEN-2:0], seq_in};
  assign fill_nx    = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign fill_ok    = (fill_nx >= {1'b0, len_q});

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len_q)) mask[i] = 1'b1;
    end
  end

  assign hit = fill_ok && ((sample_vec & mask) == (pat_q & mask));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    win_d   = win_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        // abort beats the final sample: nothing is sampled on an abort cycle.
        if (abort) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else begin
          hist_d = sample_vec;
          if (fill_q != LEN_W'(MAX_LEN)) fill_d = fill_q + LEN_W'(1);
          hit_d = hit;
          if (hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
          wcnt_d = wcnt_q - WIN_W'(1);
          if (wcnt_q == WIN_W'(1)) state_d = DONE;
        end
      end
      IDLE, ARMED, DONE: begin
        // A config accepted in the same cycle as start takes priority.
        if (cfg_take) begin
          if (cfg_legal) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            win_d   = cfg_window;
            state_d = ARMED;
          end else begin
            pat_d   = '0;
            len_d   = '0;
            win_d   = '0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (start) begin
          if (state_q == IDLE) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            wcnt_d  = win_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      win_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      win_q   <= win_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: stimulus queues expected output events
// (match pulse, err pulse, done rise, end of busy), a negedge monitor pops and compares.
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int WIN_W   = 16;
  localparam int CNT_W   = 10;

  localparam int EV_HIT  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_BUSY = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [WIN_W-1:0]   cfg_window;
  logic               start;
  logic               abort;
  logic               seq_in;
  logic               seq_out;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   det_cnt;
  logic               err;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  bit  mon_en = 1'b0;
  bit  prev_busy = 1'b0;
  bit  prev_done = 1'b0;
  int  busy_len  = 0;

  seq_det_ctrl #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .WIN_W  (WIN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_window (cfg_window),
    .start      (start),
    .abort      (abort),
    .seq_in     (seq_in),
    .seq_out    (seq_out),
    .busy       (busy),
    .done       (done),
    .det_cnt    (det_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required under 2000000", $time);
    $fatal(1);
  end

  task automatic got(input int kind, input logic [31:0] val);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL event: got kind %0d cyc %0d val %0d, required no event", kind, cyc, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc || val !== 32'(e.val)) begin
        n_bad++;
        $display("FAIL event: got kind %0d cyc %0d val %0d, required kind %0d cyc %0d val %0d",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (seq_out === 1'b1) got(EV_HIT, 32'(det_cnt));
      if (done === 1'b1 && !prev_done) got(EV_DONE, 32'(det_cnt));
      if (busy !== 1'b1 && prev_busy) got(EV_BUSY, 32'(busy_len));
      if (err === 1'b1) got(EV_ERR, 32'd0);
      busy_len  = (busy === 1'b1) ? busy_len + 1 : 0;
      prev_busy = (busy === 1'b1);
      prev_done = (done === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected event visible after the next rising edge.
  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc + 1;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic do_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic [WIN_W-1:0] win, input bit exp_err, input bit with_start);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_window  = win;
    start       = with_start;
    if (exp_err) expect_ev(EV_ERR, 0);
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic run(input logic [15:0] bits, input logic [15:0] hits, input int w,
                     input bit abort_last);
    int cnt;
    cnt   = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < w; i++) begin
      seq_in = bits[i];
      if (abort_last && i == w - 1) begin
        abort = 1'b1;
        expect_ev(EV_BUSY, w);
      end else begin
        if (hits[i]) begin
          cnt++;
          expect_ev(EV_HIT, cnt);
        end
        if (i == w - 1) begin
          expect_ev(EV_DONE, cnt);
          expect_ev(EV_BUSY, w);
        end
      end
      step();
      abort = 1'b0;
    end
    seq_in = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_window = '0;
    start = 1'b0; abort = 1'b0; seq_in = 1'b0;
    step(); step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_det_cnt", 32'(det_cnt), 32'd0);
    check("rst_seq_out", 32'(seq_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Illegal configs and start without a config
    do_cfg(8'h0B, 4'd0, 16'd16, 1'b1, 1'b0);
    check("len0_cfg_ready", 32'(cfg_ready), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    start = 1'b1; expect_ev(EV_ERR, 0); step(); start = 1'b0;
    check("idle_start_busy", 32'(busy), 32'd0);
    do_cfg(8'h0B, 4'd9, 16'd16, 1'b1, 1'b0);
    do_cfg(8'h0B, 4'd4, 16'd0, 1'b1, 1'b0);
    step();

    // Pattern 1011 over a 16-sample window
    do_cfg(8'h0B, 4'd4, 16'd16, 1'b0, 1'b0);
    check("armed_cfg_ready", 32'(cfg_ready), 32'd1);
    run(16'b1110_1101_1001_1100, 16'h4800, 16, 1'b0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_det_cnt", 32'(det_cnt), 32'd2);
    step(); step();
    check("t1_det_cnt_held", 32'(det_cnt), 32'd2);

    // Overlapping matches of 11
    do_cfg(8'h03, 4'd2, 16'd5, 1'b0, 1'b0);
    run(16'h001F, 16'b11110, 5, 1'b0);
    check("ovl_det_cnt", 32'(det_cnt), 32'd4);

    // start with a legal config from DONE: config wins
    do_cfg(8'h03, 4'd2, 16'd4, 1'b0, 1'b1);
    check("sim_busy", 32'(busy), 32'd0);
    check("sim_done", 32'(done), 32'd0);
    check("sim_cfg_ready", 32'(cfg_ready), 32'd1);

    // abort on the last window sample
    run(16'h000F, 16'b0110, 4, 1'b1);
    check("abort_det_cnt", 32'(det_cnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    run(16'h000F, 16'b1110, 4, 1'b0);
    check("rerun_det_cnt", 32'(det_cnt), 32'd3);

    // Saturation over 1100 samples
    do_cfg(8'h01, 4'd1, 16'd1100, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      seq_in = 1'b1;
      if (cnt < 1023) cnt++;
      expect_ev(EV_HIT, cnt);
      if (i == 1099) begin
        expect_ev(EV_DONE, cnt);
        expect_ev(EV_BUSY, 1100);
      end
      step();
    end
    seq_in = 1'b0;
    check("sat_det_cnt", 32'(det_cnt), 32'd1023);
    check("sat_done", 32'(done), 32'd1);
    step(); step(); step();
    check("sat_det_cnt_held", 32'(det_cnt), 32'd1023);

    // Reset in the middle of a run
    do_cfg(8'h01, 4'd1, 16'd16, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seq_in = 1'b1;
      expect_ev(EV_HIT, i + 1);
      step();
    end
    rst = 1'b1;
    expect_ev(EV_BUSY, 6);
    step();
    rst = 1'b0;
    seq_in = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_det_cnt", 32'(det_cnt), 32'd0);
    check("mrst_seq_out", 32'(seq_out), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_cfg_ready", 32'(cfg_ready), 32'd1);
    start = 1'b1; expect_ev(EV_ERR, 0); step(); start = 1'b0;
    check("mrst_start_busy", 32'(busy), 32'd0);

    step(); step(); step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
